// File: rtl/icache_nway_if.sv
// Fetch bus between a requester and a responder: request fields flow master->slave,
// mem_ready/mem_rdata flow back.
interface icache_nway_if;
  logic        mem_valid;
  logic        mem_fence;
  logic        mem_instr;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_ready;
  logic [31:0] mem_rdata;

  modport master (
    output mem_valid, mem_fence, mem_instr, mem_addr, mem_wdata, mem_wstrb,
    input  mem_ready, mem_rdata
  );

  modport slave (
    input  mem_valid, mem_fence, mem_instr, mem_addr, mem_wdata, mem_wstrb,
    output mem_ready, mem_rdata
  );
endinterface

// File: rtl/icache_nway.sv
// N-way set-associative instruction cache: hit in one cycle, line refill from imem, fence sweep.
// Replacement is a global round-robin pointer; define ICACHE_PLRU_EN for per-set tree pseudo-LRU.
module icache_nway #(
  parameter int WAYS  = 2,
  parameter int DEPTH = 4,
  parameter int WIDTH = 2
) (
  input  logic          clk,
  input  logic          rst,
  icache_nway_if.slave  icache,
  icache_nway_if.master imem
);
  localparam int SETS  = 2**DEPTH;
  localparam int WORDS = 2**WIDTH;
  localparam int TAGW  = 30-(DEPTH+WIDTH);
  localparam int LINEW = WORDS*32;
  localparam int WB    = (WAYS > 1) ? $clog2(WAYS) : 1;
  localparam int TLSB  = DEPTH+WIDTH+2;

  typedef enum logic [1:0] {INVAL, HIT, REFILL} state_t;
  state_t state_q, state_d;

  logic [TAGW-1:0]           tag_mem_q  [WAYS][SETS];
  logic [LINEW-1:0]          data_mem_q [WAYS][SETS];
  logic [WAYS-1:0][SETS-1:0] vld_q;

  logic [TAGW-1:0]  rd_tag_q  [WAYS];
  logic [LINEW-1:0] rd_data_q [WAYS];
  logic [WAYS-1:0]  rd_vld_q;

  logic [31:0]      addr_q, addr_d;
  logic [DEPTH-1:0] cnt_q, cnt_d;
  logic             fence_q, fence_d, req_q, req_d, rdy_q, rdy_d, ivld_q, ivld_d;
  logic [31:0]      rdata_q, rdata_d;
  logic [WIDTH-1:0] beat_q, beat_d;
  logic [WB-1:0]    way_q, way_d;
  logic [LINEW-1:0] line_q, line_d;

  logic [TAGW-1:0]  tag_a;
  logic [DEPTH-1:0] set_a, set_in;
  logic [WIDTH-1:0] word_a;
  assign tag_a  = addr_q[31:TLSB];
  assign set_a  = addr_q[TLSB-1:WIDTH+2];
  assign word_a = addr_q[WIDTH+1:2];
  assign set_in = icache.mem_addr[TLSB-1:WIDTH+2];

  logic            accept, inv_we, fill_we, upd_we, rr_inc, hit_rdy, hit_any;
  logic [WAYS-1:0] hit_vec;
  logic [WB-1:0]   hit_way, upd_way, victim, repl_way;
  logic [31:0]     hit_word;

  always_comb begin
    hit_vec = '0;
    hit_way = '0;
    for (int w = 0; w < WAYS; w++) begin
      hit_vec[w] = rd_vld_q[w] && (rd_tag_q[w] == tag_a);
      if (hit_vec[w]) hit_way = WB'(w);
    end
    hit_any  = |hit_vec;
    hit_word = rd_data_q[hit_way][word_a*32 +: 32];
  end

  // Empty ways are filled lowest-first before the replacement policy gets a say.
  always_comb begin
    victim = repl_way;
    for (int w = WAYS-1; w >= 0; w--)
      if (!rd_vld_q[w]) victim = WB'(w);
  end

`ifdef ICACHE_PLRU_EN
  logic [2:0] plru_q [SETS];
  logic       unused_repl;
  assign unused_repl = rr_inc;

  // Tree bits point at the victim: b0 picks the pair, b1/b2 pick inside it.
  function automatic logic [WB-1:0] plru_victim(input logic [2:0] b);
    if (WAYS == 4) return WB'({b[0], b[0] ? b[2] : b[1]});
    return (WAYS > 1) ? WB'(b[0]) : '0;
  endfunction

  function automatic logic [2:0] plru_upd(input logic [2:0] b, input logic [WB-1:0] w);
    logic [2:0] r;
    logic [1:0] w2;
    r  = b;
    w2 = 2'(w);
    if (WAYS == 4) begin
      r[0] = ~w2[1];
      if (w2[1]) r[2] = ~w2[0];
      else       r[1] = ~w2[0];
    end else begin
      r[0] = ~w2[0];
    end
    return r;
  endfunction

  assign repl_way = plru_victim(plru_q[set_a]);

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int s = 0; s < SETS; s++) plru_q[s] <= '0;
    end else if (upd_we) begin
      plru_q[set_a] <= plru_upd(plru_q[set_a], upd_way);
    end
  end
`else
  logic [WB-1:0] rr_q;
  logic          unused_repl;
  assign unused_repl = ^{upd_we, upd_way};
  assign repl_way    = rr_q;

  always_ff @(posedge clk) begin
    if (rst)         rr_q <= '0;
    else if (rr_inc) rr_q <= (rr_q == WB'(WAYS-1)) ? '0 : rr_q + 1'b1;
  end
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    fence_d = fence_q;
    req_d   = 1'b0;
    rdy_d   = 1'b0;
    rdata_d = '0;
    ivld_d  = ivld_q;
    beat_d  = beat_q;
    way_d   = way_q;
    line_d  = line_q;
    addr_d  = addr_q;
    accept  = 1'b0;
    inv_we  = 1'b0;
    fill_we = 1'b0;
    upd_we  = 1'b0;
    upd_way = hit_way;
    rr_inc  = 1'b0;
    hit_rdy = 1'b0;
    case (state_q)
      INVAL: begin
        inv_we = 1'b1;
        cnt_d  = cnt_q + 1'b1;
        if (cnt_q == DEPTH'(SETS-1)) begin
          state_d = HIT;
          rdy_d   = fence_q;
          fence_d = 1'b0;
        end
      end
      HIT: begin
        if (req_q) begin
          if (hit_any) begin
            hit_rdy = 1'b1;
            upd_we  = 1'b1;
          end else begin
            state_d = REFILL;
            way_d   = victim;
            ivld_d  = 1'b1;
            beat_d  = '0;
            rr_inc  = &rd_vld_q;
          end
        // rdy_q blocks re-acceptance of the request still held in the completion cycle
        end else if (icache.mem_valid && !rdy_q) begin
          addr_d = icache.mem_addr;
          if (icache.mem_fence) begin
            state_d = INVAL;
            cnt_d   = '0;
            fence_d = 1'b1;
          end else begin
            req_d  = 1'b1;
            accept = 1'b1;
          end
        end
      end
      REFILL: begin
        if (ivld_q && imem.mem_ready) begin
          line_d[beat_q*32 +: 32] = imem.mem_rdata;
          beat_d = beat_q + 1'b1;
          if (beat_q == WIDTH'(WORDS-1)) begin
            fill_we = 1'b1;
            upd_we  = 1'b1;
            upd_way = way_q;
            ivld_d  = 1'b0;
            rdy_d   = 1'b1;
            rdata_d = line_d[word_a*32 +: 32];
            state_d = HIT;
          end
        end
      end
      default: state_d = INVAL;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= INVAL;
    else     state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q   <= '0;
      fence_q <= 1'b0;
      req_q   <= 1'b0;
      rdy_q   <= 1'b0;
      rdata_q <= '0;
      ivld_q  <= 1'b0;
      beat_q  <= '0;
      way_q   <= '0;
      line_q  <= '0;
      addr_q  <= '0;
    end else begin
      cnt_q   <= cnt_d;
      fence_q <= fence_d;
      req_q   <= req_d;
      rdy_q   <= rdy_d;
      rdata_q <= rdata_d;
      ivld_q  <= ivld_d;
      beat_q  <= beat_d;
      way_q   <= way_d;
      line_q  <= line_d;
      addr_q  <= addr_d;
    end
  end

  // Tag/data storage is never cleared; only valid bits gate its use.
  always_ff @(posedge clk) begin
    if (accept) begin
      for (int w = 0; w < WAYS; w++) begin
        rd_tag_q[w]  <= tag_mem_q[w][set_in];
        rd_data_q[w] <= data_mem_q[w][set_in];
        rd_vld_q[w]  <= vld_q[w][set_in];
      end
    end
    if (fill_we && !rst) begin
      tag_mem_q[way_q][set_a]  <= tag_a;
      data_mem_q[way_q][set_a] <= line_d;
    end
  end

  always_ff @(posedge clk) begin
    if (inv_we) begin
      for (int w = 0; w < WAYS; w++) vld_q[w][cnt_q] <= 1'b0;
    end
    if (fill_we && !rst) vld_q[way_q][set_a] <= 1'b1;
  end

  assign icache.mem_ready = hit_rdy | rdy_q;
  assign icache.mem_rdata = hit_rdy ? hit_word : rdata_q;

  assign imem.mem_valid = ivld_q;
  assign imem.mem_fence = 1'b0;
  assign imem.mem_instr = 1'b1;
  assign imem.mem_addr  = {addr_q[31:WIDTH+2], beat_q, 2'b00};
  assign imem.mem_wdata = '0;
  assign imem.mem_wstrb = '0;

  logic unused_in;
  assign unused_in = ^{icache.mem_instr, icache.mem_wdata, icache.mem_wstrb, addr_q[1:0]};
endmodule
